// File: rtl/data_mem_responder.sv
// Memory-side responder for the multi-cycle CPU data-access stage: captures one
// request, waits WAIT_CYCLES, then commits and answers with a one-cycle mem_ready pulse.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_flag,
    input  logic        mem_write_flag,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

    localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);
    localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        op_wr_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic [31:0] rdata_r;
    logic        mem_ready_r;
    logic        mem_err_r;
    logic        busy_r;

    logic [31:0] mem_r [0:(1 << ADDR_W) - 1];

    logic              req_one_s;
    logic              req_both_s;
    logic              req_any_s;
    logic              commit_s;
    logic              acc_rd_s;
    logic              acc_wr_s;
    logic              acc_both_s;
    logic              acc_err_s;
    logic [31:0]       acc_addr_s;
    logic [31:0]       acc_wdata_s;
    logic [3:0]        acc_wstrb_s;
    logic [ADDR_W-1:0] idx_s;

    // Misaligned or beyond the implemented word array
    function automatic logic addr_bad(input logic [31:0] a);
        addr_bad = (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign req_one_s  = mem_read_flag ^ mem_write_flag;
    assign req_both_s = mem_read_flag & mem_write_flag;
    assign req_any_s  = mem_read_flag | mem_write_flag;

    // Select the access that commits on this edge; zero-wait and rd&wr cases use live inputs
    always_comb begin
        commit_s    = 1'b0;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        acc_wstrb_s = wstrb_r;
        acc_wr_s    = op_wr_r;
        acc_rd_s    = ~op_wr_r;
        acc_both_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_both_s) begin
                    commit_s   = 1'b1;
                    acc_addr_s = addr;
                    acc_both_s = 1'b1;
                    acc_rd_s   = 1'b1;
                    acc_wr_s   = 1'b0;
                end else if (req_one_s && ZERO_WAIT) begin
                    commit_s    = 1'b1;
                    acc_addr_s  = addr;
                    acc_wdata_s = wdata;
                    acc_wstrb_s = wstrb;
                    acc_wr_s    = mem_write_flag;
                    acc_rd_s    = mem_read_flag;
                end else begin
                    commit_s = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    commit_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            default: commit_s = 1'b0;
        endcase
    end

    assign acc_err_s = acc_both_s | addr_bad(acc_addr_s);
    assign idx_s     = acc_addr_s[ADDR_W+1:2];

    // Request FSM with registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            op_wr_r     <= 1'b0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            wstrb_r     <= 4'd0;
            rdata_r     <= 32'd0;
            mem_ready_r <= 1'b0;
            mem_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            mem_ready_r <= commit_s;
            mem_err_r   <= commit_s & acc_err_s;
            if (commit_s && acc_rd_s) begin
                rdata_r <= acc_err_s ? 32'd0 : mem_r[idx_s];
            end
            case (state_r)
                IDLE: begin
                    if (req_both_s) begin
                        state_r <= RESP;
                        busy_r  <= 1'b1;
                    end else if (req_one_s) begin
                        op_wr_r <= mem_write_flag;
                        addr_r  <= addr;
                        wdata_r <= wdata;
                        wstrb_r <= wstrb;
                        busy_r  <= 1'b1;
                        if (ZERO_WAIT) begin
                            state_r <= RESP;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= WAIT_LD;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                WAIT: begin
                    busy_r <= 1'b1;
                    if (cnt_r == 4'd1) begin
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (req_any_s) begin
                        state_r <= HOLD;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (req_any_s) begin
                        busy_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Word array is deliberately left unreset so contents survive rst
    always_ff @(posedge clk) begin
        if (commit_s && acc_wr_s && !acc_err_s) begin
            mem_r[idx_s] <= merge_lanes(mem_r[idx_s], acc_wdata_s, acc_wstrb_s);
        end
    end

    assign rdata     = rdata_r;
    assign mem_ready = mem_ready_r;
    assign mem_err   = mem_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (ADDR_W=8, WAIT_CYCLES=2): stimulus pushes
// expected responses, a negedge monitor pops and checks them including arrival cycle.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        mem_ready;
    logic        mem_err;
    logic        busy;

    typedef struct {
        int          cyc;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    int   cyc;

    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
        .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .mem_ready(mem_ready), .mem_err(mem_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", nm, got, exp);
        end
    endtask

    // Monitor: every mem_ready must match the oldest expected response
    always @(negedge clk) begin
        if (mem_ready === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: mem_ready=1 at cycle %0d with nothing expected", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                check({e.name, "_err"}, {31'd0, mem_err}, {31'd0, e.err});
                if (e.chk) check({e.name, "_rdata"}, rdata, e.rdata);
            end
        end else if (!rst) begin
            check("err_without_ready", {31'd0, mem_err}, 32'd0);
        end
    end

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: %0d responses missing, expected 0", nm, q.size());
            q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input int lat,
                         input logic err, input logic chk, input logic [31:0] exp,
                         input string nm);
        @(posedge clk); #1;
        mem_read_flag  = rd;
        mem_write_flag = wr;
        addr           = a;
        wdata          = d;
        wstrb          = s;
        q.push_back('{cyc + lat, err, chk, exp, nm});
        @(posedge clk); #1;
        mem_read_flag  = 1'b0;
        mem_write_flag = 1'b0;
        wait_drain(nm);
    endtask

    initial begin
        int t;
        total = 0; bad = 0; cyc = 0;
        mem_read_flag = 1'b0; mem_write_flag = 1'b0;
        addr = 32'd0; wdata = 32'd0; wstrb = 4'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_rdata", rdata, 32'd0);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 1'b0, 1'b0, 32'd0, "wr_full");
        issue(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF, "rd_full");
        issue(1'b0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, 3, 1'b0, 1'b0, 32'd0, "wr_lane1");
        issue(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 3, 1'b0, 1'b1, 32'hDEADABEF, "rd_lane1");
        issue(1'b1, 1'b0, 32'h13, 32'd0, 4'h0, 3, 1'b1, 1'b1, 32'd0, "rd_misaligned");
        issue(1'b1, 1'b0, 32'h400, 32'd0, 4'h0, 3, 1'b1, 1'b1, 32'd0, "rd_out_of_range");
        issue(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 3, 1'b0, 1'b1, 32'hDEADABEF, "rd_after_err");

        // rd and wr together: error response one cycle later, busy for that cycle only
        @(posedge clk); #1;
        mem_read_flag = 1'b1; mem_write_flag = 1'b1;
        addr = 32'h10; wdata = 32'd0; wstrb = 4'hF;
        q.push_back('{cyc + 1, 1'b1, 1'b0, 32'd0, "rdwr_both"});
        check("both_busy_T", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        mem_read_flag = 1'b0; mem_write_flag = 1'b0;
        check("both_busy_T1", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("both_busy_T2", {31'd0, busy}, 32'd0);
        wait_drain("rdwr_both");
        issue(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 3, 1'b0, 1'b1, 32'hDEADABEF, "rd_after_both");

        issue(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 3, 1'b0, 1'b0, 32'd0, "wr_nostrb");
        issue(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 3, 1'b0, 1'b1, 32'hDEADABEF, "rd_after_nostrb");

        // Level read held: one pulse, then drop for one cycle and reassert for a second
        @(posedge clk); #1;
        mem_read_flag = 1'b1; addr = 32'h10;
        t = cyc;
        q.push_back('{t + 3, 1'b0, 1'b1, 32'hDEADABEF, "hold_first"});
        repeat (13) @(posedge clk);
        #1 mem_read_flag = 1'b0;
        @(posedge clk); #1;
        mem_read_flag = 1'b1;
        q.push_back('{cyc + 3, 1'b0, 1'b1, 32'hDEADABEF, "hold_second"});
        repeat (6) @(posedge clk);
        #1 mem_read_flag = 1'b0;
        wait_drain("hold");

        // Reset while a write waits: nothing commits and no response appears
        @(posedge clk); #1;
        mem_write_flag = 1'b1; addr = 32'h10; wdata = 32'h12345678; wstrb = 4'hF;
        @(posedge clk); #1;
        mem_write_flag = 1'b0;
        check("abort_busy_wait", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        check("abort_ready", {31'd0, mem_ready}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        issue(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 3, 1'b0, 1'b1, 32'hDEADABEF, "rd_after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
